// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron layer blocks: sequencer states, default
// fixed-point constants and the output activation/saturation helper.
package neuron_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      BIAS,
      OUT
   } state_t;

   localparam int DEF_FRAC_BITS = 8;
   localparam int DEF_ACC_WIDTH = 40;

   // Common carrier width so one helper serves every accumulator width up to 64.
   localparam int WIDE_WIDTH = 64;
   typedef logic signed [WIDE_WIDTH-1:0] wide_t;

   function automatic wide_t activate_saturate(input wide_t value,
                                               input int    data_width,
                                               input bit    use_relu);
      wide_t max_val;
      wide_t min_val;
      wide_t result;
      max_val = (wide_t'(1) <<< (data_width - 1)) - wide_t'(1);
      min_val = -(wide_t'(1) <<< (data_width - 1));
      result  = value;
      if (use_relu && (result < 0)) result = '0;
      if (result > max_val)      result = max_val;
      else if (result < min_val) result = min_val;
      return result;
   endfunction

endpackage

// File: rtl/neuron_sequencer_if.sv
// Memory read bus and output stream of one neuron sequencer; master is the
// sequencer, slave is the weight/input memories plus the downstream consumer.
interface neuron_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 10
);

   logic                  rd_en;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DATA_WIDTH-1:0] weight_in;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output rd_en, rd_addr, out_data, out_valid,
      input  weight_in, data_in, out_ready
   );

   modport slave (
      input  rd_en, rd_addr, out_data, out_valid,
      output weight_in, data_in, out_ready
   );

endinterface

// File: rtl/neuron_mac.sv
// Registered signed multiply-accumulate with synchronous clear, valid-qualified
// product accumulation and a bias-add step that aligns bias to the product scale.
module neuron_mac
   import neuron_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clear,
   input  logic                         valid,
   input  logic                         bias_add,
   input  logic signed [DATA_WIDTH-1:0] weight,
   input  logic signed [DATA_WIDTH-1:0] data,
   input  logic signed [DATA_WIDTH-1:0] bias,
   output logic signed [ACC_WIDTH-1:0]  acc
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;

   logic signed [PROD_WIDTH-1:0] product;

   assign product = PROD_WIDTH'(weight) * PROD_WIDTH'(data);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else if (valid) begin
         acc <= acc + ACC_WIDTH'(product);
      end else if (bias_add) begin
         acc <= acc + (ACC_WIDTH'(bias) <<< FRAC_BITS);
      end
   end

endmodule

// File: rtl/neuron_sequencer.sv
// One fully-connected neuron: walks weight row and input buffer, accumulates the
// products, adds bias, activates/saturates and offers the result on a handshake.
module neuron_sequencer
   import neuron_pkg::*;
#(
   parameter int NUM_INPUTS = 784,
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = DEF_FRAC_BITS,
   parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
   parameter int USE_RELU   = 1,
   // A single-input neuron still needs a one-bit address port.
   localparam int ADDR_WIDTH = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   output logic                         busy,
   input  logic signed [DATA_WIDTH-1:0] bias_in,
   neuron_sequencer_if.master           bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_INPUTS - 1);

   state_t                  state;
   state_t                  state_next;
   logic                    rd_valid;
   logic                    rd_en_next;
   logic [ADDR_WIDTH-1:0]   rd_addr_next;
   logic [DATA_WIDTH-1:0]   out_data_next;
   logic                    out_valid_next;
   logic                    mac_clear;
   logic                    mac_bias_add;
   logic signed [ACC_WIDTH-1:0] acc;

   assign busy = (state != IDLE);

   neuron_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .ACC_WIDTH  (ACC_WIDTH)
   ) u_mac (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (mac_clear),
      .valid    (rd_valid),
      .bias_add (mac_bias_add),
      .weight   (bus.weight_in),
      .data     (bus.data_in),
      .bias     (bias_in),
      .acc      (acc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         rd_valid      <= 1'b0;
         bus.rd_en     <= 1'b0;
         bus.rd_addr   <= '0;
         bus.out_data  <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         state         <= state_next;
         rd_valid      <= bus.rd_en;
         bus.rd_en     <= rd_en_next;
         bus.rd_addr   <= rd_addr_next;
         bus.out_data  <= out_data_next;
         bus.out_valid <= out_valid_next;
      end
   end

   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      state_next     = state;
      rd_en_next     = bus.rd_en;
      rd_addr_next   = bus.rd_addr;
      out_data_next  = bus.out_data;
      out_valid_next = bus.out_valid;
      mac_clear      = 1'b0;
      mac_bias_add   = 1'b0;

      unique case (state)
         IDLE: begin
            mac_clear = 1'b1;
            if (start) begin
               rd_en_next   = 1'b1;
               rd_addr_next = '0;
               state_next   = FETCH;
            end
         end
         FETCH: begin
            if (bus.rd_addr == LAST_ADDR) begin
               rd_en_next = 1'b0;
               state_next = DRAIN;
            end else begin
               rd_addr_next = bus.rd_addr + ADDR_WIDTH'(1);
            end
         end
         DRAIN: state_next = BIAS;
         BIAS: begin
            mac_bias_add = 1'b1;
            state_next   = OUT;
         end
         OUT: begin
            if (!bus.out_valid) begin
               out_data_next  = DATA_WIDTH'(activate_saturate(wide_t'(acc >>> FRAC_BITS),
                                                              DATA_WIDTH, USE_RELU != 0));
               out_valid_next = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_next = 1'b0;
               state_next     = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_neuron_sequencer.sv
// Directed bench: two 4-input neurons (ReLU and linear) in lockstep plus a
// single-input neuron, each with a one-cycle-latency memory model.
module tb_neuron_sequencer;

   logic clk;
   logic rst_n;

   logic        start_ab;
   logic        ready_ab;
   logic [15:0] bias_ab;
   logic        busy_a;
   logic        busy_b;
   logic [15:0] w4 [4];
   logic [15:0] x4 [4];

   logic        start_c;
   logic        ready_c;
   logic [15:0] bias_c;
   logic        busy_c;
   logic [15:0] w1;
   logic [15:0] x1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string           name;
      logic [3:0][15:0] w;
      logic [3:0][15:0] x;
      logic [15:0]     bias;
      logic [15:0]     exp_relu;
      logic [15:0]     exp_lin;
   } vec_t;

   vec_t vecs [6];

   neuron_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus_a ();
   neuron_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(2)) bus_b ();
   neuron_sequencer_if #(.DATA_WIDTH(16), .ADDR_WIDTH(1)) bus_c ();

   assign bus_a.out_ready = ready_ab;
   assign bus_b.out_ready = ready_ab;
   assign bus_c.out_ready = ready_c;

   neuron_sequencer #(.NUM_INPUTS(4), .DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .USE_RELU(1))
      dut_a (.clk(clk), .rst_n(rst_n), .start(start_ab), .busy(busy_a), .bias_in(bias_ab), .bus(bus_a));
   neuron_sequencer #(.NUM_INPUTS(4), .DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .USE_RELU(0))
      dut_b (.clk(clk), .rst_n(rst_n), .start(start_ab), .busy(busy_b), .bias_in(bias_ab), .bus(bus_b));
   neuron_sequencer #(.NUM_INPUTS(1), .DATA_WIDTH(16), .FRAC_BITS(8), .ACC_WIDTH(40), .USE_RELU(0))
      dut_c (.clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .bias_in(bias_c), .bus(bus_c));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memories: data appears one cycle after the read request.
   always @(posedge clk) begin
      if (bus_a.rd_en) begin
         bus_a.weight_in <= w4[bus_a.rd_addr];
         bus_a.data_in   <= x4[bus_a.rd_addr];
      end
      if (bus_b.rd_en) begin
         bus_b.weight_in <= w4[bus_b.rd_addr];
         bus_b.data_in   <= x4[bus_b.rd_addr];
      end
      if (bus_c.rd_en) begin
         bus_c.weight_in <= w1;
         bus_c.data_in   <= x1;
      end
   end

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic vec_t mk(input string name,
                               input logic [15:0] w0, w1v, w2, w3,
                               input logic [15:0] x0, x1v, x2, x3,
                               input logic [15:0] b, er, el);
      vec_t v;
      v.name = name;
      v.w[0] = w0; v.w[1] = w1v; v.w[2] = w2; v.w[3] = w3;
      v.x[0] = x0; v.x[1] = x1v; v.x[2] = x2; v.x[3] = x3;
      v.bias = b;
      v.exp_relu = er;
      v.exp_lin  = el;
      return v;
   endfunction

   // Starts both 4-input neurons and returns once out_valid is seen (or times out).
   task automatic run_ab(input int i);
      int c;
      for (int k = 0; k < 4; k++) begin
         w4[k] = vecs[i].w[k];
         x4[k] = vecs[i].x[k];
      end
      bias_ab = vecs[i].bias;
      @(negedge clk);
      start_ab = 1'b1;
      @(posedge clk);
      #1;
      start_ab = 1'b0;
      check($sformatf("%s rd_en_first", vecs[i].name), bus_a.rd_en, 1);
      check($sformatf("%s rd_addr_0", vecs[i].name), bus_a.rd_addr, 0);
      check($sformatf("%s busy", vecs[i].name), busy_a, 1);
      c = 0;
      while (!bus_a.out_valid && c < 20) begin
         @(posedge clk);
         #1;
         c++;
         if (c <= 3) check($sformatf("%s rd_addr_%0d", vecs[i].name, c), bus_a.rd_addr, c);
         if (c == 4) check($sformatf("%s rd_en_off", vecs[i].name), bus_a.rd_en, 0);
      end
      check($sformatf("%s latency", vecs[i].name), c, 7);
      check($sformatf("%s relu_data", vecs[i].name), bus_a.out_data, vecs[i].exp_relu);
      check($sformatf("%s lin_valid", vecs[i].name), bus_b.out_valid, 1);
      check($sformatf("%s lin_data", vecs[i].name), bus_b.out_data, vecs[i].exp_lin);
   endtask

   task automatic run_c(input string name, input logic [15:0] w, x, b, expv);
      int c;
      w1 = w;
      x1 = x;
      bias_c = b;
      @(negedge clk);
      start_c = 1'b1;
      @(posedge clk);
      #1;
      start_c = 1'b0;
      check($sformatf("%s rd_addr", name), bus_c.rd_addr, 0);
      c = 0;
      while (!bus_c.out_valid && c < 20) begin
         @(posedge clk);
         #1;
         c++;
      end
      check($sformatf("%s latency", name), c, 4);
      check($sformatf("%s data", name), bus_c.out_data, expv);
      @(posedge clk);
      #1;
      check($sformatf("%s valid_drop", name), bus_c.out_valid, 0);
      check($sformatf("%s idle", name), busy_c, 0);
   endtask

   initial begin
      vecs[0] = mk("base", 16'h0100, 16'h0200, 16'hFF00, 16'h0080,
                   16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0080, 16'h0380, 16'h0380);
      vecs[1] = mk("neg_bias", 16'h0100, 16'h0200, 16'hFF00, 16'h0080,
                   16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'hFB00, 16'h0000, 16'hFE00);
      vecs[2] = mk("neg_bias_half", 16'h0100, 16'h0200, 16'hFF00, 16'h0080,
                   16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'hFB80, 16'h0000, 16'hFE80);
      vecs[3] = mk("sat_pos", 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                   16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h0000, 16'h7FFF, 16'h7FFF);
      vecs[4] = mk("sat_neg", 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
                   16'h8100, 16'h8100, 16'h8100, 16'h8100, 16'h0000, 16'h0000, 16'h8000);
      vecs[5] = mk("trunc_neg", 16'hFFFF, 16'h0000, 16'h0000, 16'h0000,
                   16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF);

      rst_n = 1'b0;
      start_ab = 1'b0;
      start_c = 1'b0;
      ready_ab = 1'b0;
      ready_c = 1'b1;
      bias_ab = '0;
      bias_c = '0;
      w1 = '0;
      x1 = '0;
      for (int k = 0; k < 4; k++) begin
         w4[k] = '0;
         x4[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("reset busy", busy_a, 0);
      check("reset rd_en", bus_a.rd_en, 0);
      check("reset rd_addr", bus_a.rd_addr, 0);
      check("reset out_valid", bus_a.out_valid, 0);
      check("reset out_data", bus_a.out_data, 0);
      check("reset busy_c", busy_c, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Table of 4-input vectors with immediate acceptance.
      ready_ab = 1'b1;
      for (int i = 0; i < 6; i++) begin
         run_ab(i);
         @(posedge clk);
         #1;
         check($sformatf("%s valid_drop", vecs[i].name), bus_a.out_valid, 0);
         check($sformatf("%s idle", vecs[i].name), busy_a, 0);
      end

      // Backpressure: result held for 10 cycles while start pulses are ignored.
      ready_ab = 1'b0;
      run_ab(0);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         start_ab = k[0];
         @(posedge clk);
         #1;
         check("stall data", bus_a.out_data, 16'h0380);
         check("stall valid", bus_a.out_valid, 1);
         check("stall busy", busy_a, 1);
      end
      @(negedge clk);
      start_ab = 1'b1;
      ready_ab = 1'b1;
      @(posedge clk);
      #1;
      start_ab = 1'b0;
      check("stall release valid", bus_a.out_valid, 0);
      check("stall release busy", busy_a, 0);
      @(posedge clk);
      #1;
      check("start on handshake ignored", busy_a, 0);

      // Asynchronous reset while address 2 is on the bus, then a clean rerun.
      for (int k = 0; k < 4; k++) begin
         w4[k] = vecs[0].w[k];
         x4[k] = vecs[0].x[k];
      end
      bias_ab = vecs[0].bias;
      @(negedge clk);
      start_ab = 1'b1;
      @(posedge clk);
      #1;
      start_ab = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort at addr", bus_a.rd_addr, 2);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", busy_a, 0);
      check("abort rd_en", bus_a.rd_en, 0);
      check("abort rd_addr", bus_a.rd_addr, 0);
      check("abort out_valid", bus_a.out_valid, 0);
      check("abort out_data", bus_a.out_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_ab(0);
      @(posedge clk);
      #1;
      check("rerun idle", busy_a, 0);

      // Single-input neuron, back-to-back evaluations.
      run_c("one_a", 16'h0100, 16'h0100, 16'h0000, 16'h0100);
      run_c("one_b", 16'h0200, 16'hFF00, 16'h0080, 16'hFE80);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
